btn_event_arbiter: RTL and testbench
====================================

# btn_event_arbiter

Multi-button input controller that sits between the board push-buttons and the downstream command consumer, such as the top-level game/CPU control FSM. It synchronises and debounces each raw button and turns each clean press into a single pending event. It then serves pending events one at a time to a valid/ready consumer using round-robin arbitration. This replaces per-button ad-hoc edge detectors with one block that owns all button sequencing.

## Interface
- N_BTN, 4: number of buttons, 2..16.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a level change, ≥2.
- REPEAT_DELAY, 1000: cycles from press to first auto-repeat. Used only with BTN_AUTO_REPEAT_EN.
- REPEAT_PERIOD, 250: cycles between subsequent auto-repeats. Used only with BTN_AUTO_REPEAT_EN.

Ports:
- clk: input, 1 bit. System clock.
- reset: input, 1 bit. Asynchronous, active-high reset.
- btn_in: input, N_BTN bits. Raw, asynchronous button levels, active-high.
- evt_valid: output, 1 bit. An event is offered.
- evt_ready: input, 1 bit. Consumer accepts the event.
- evt_id: output, clog2(N_BTN) bits. Index of the offered button.
- pending: output, N_BTN bits. Per-button pending-event flags.
- overrun: output, N_BTN bits. Sticky per-button flag: a press was lost.

## Operation
- **Per button, synchroniser.** A 2-flop synchroniser produces `sync[i]`.
- **Per button, debounce.** A counter tracks the filtered level `stable[i]`.
  - While `sync[i] == stable[i]`, the counter is 0.
  - While they differ, the counter increments.
  - On the cycle the counter would reach DEBOUNCE_CYCLES, `stable[i]` takes the value of `sync[i]` and the counter clears.
- **Press detect.** A 0→1 transition on `stable[i]` sets `pending[i]` on the next edge.
  - If `pending[i]` is already set at that point, `overrun[i]` is set instead.
- **Arbiter FSM, two states.**
  - IDLE: if `pending` is nonzero, select the first set bit searching from `last_grant+1` upward with wrap. Latch it into `evt_id` and go to OFFER.
  - OFFER: `evt_valid=1`; `evt_id` is held stable.
    - On `evt_valid && evt_ready`: clear `pending[evt_id]` and `overrun[evt_id]`, set `last_grant=evt_id`, return to IDLE.
    - Without ready: stay in OFFER indefinitely. Other buttons keep accumulating `pending`.
- **Simultaneous events.**
  - A new press on button k in the same cycle that k is accepted: `pending[k]` remains set; `overrun[k]` is not set.
  - Several presses qualifying in the same cycle: all set `pending`. Service order is round-robin.
- Releases never generate events.

## Timing
- **Reset values.**
  - Outputs: `evt_valid=0`, `evt_id=0`, `pending=0`, `overrun=0`.
  - Internal: sync flops, `stable`, and counters are 0; `last_grant=N_BTN-1`, so index 0 is searched first; FSM is in IDLE.
- **Buttons held through reset.** `stable` starts at 0, so a button held through reset release yields one press after debounce.
- **Latency.** With `btn_in[i]` rising and held before edge 0:
  - `sync` high after edge 1.
  - `stable` high after edge 1+DEBOUNCE_CYCLES.
  - `pending` high after edge 2+DEBOUNCE_CYCLES.
  - `evt_valid` high after edge 3+DEBOUNCE_CYCLES.
- **Bounce rejection.** A glitch shorter than DEBOUNCE_CYCLES produces no event.
- **Throughput.** At most one event per 2 cycles, since the FSM passes through IDLE after each accept.
- **Reset mid-operation.** Reset asserted while in OFFER drops `evt_valid` immediately (asynchronous). The event is lost and not replayed.

## Configuration
- **Macro: `BTN_AUTO_REPEAT_EN`.**
- **Defined.** A per-button repeat counter runs while `stable[i]==1`.
  - The first repeat occurs REPEAT_DELAY cycles after the press.
  - Later repeats occur every REPEAT_PERIOD cycles.
  - Each repeat acts exactly like a press, including overrun rules.
  - The counter clears when `stable[i]` falls.
- **Undefined.** Exactly one event per press. The REPEAT parameters are unused and no repeat counters are synthesised.

## Structure
- **Package `btn_pkg`.**
  - FSM state enum: IDLE, OFFER.
  - Counter width helper: `clog2` of DEBOUNCE_CYCLES and of the repeat params.
  - Default parameter constants.
- **Sub-module `btn_debounce`**, one instance per button via generate. It contains:
  - the synchroniser,
  - the debounce counter,
  - the press pulse output,
  - the optional repeat logic.
- The top level holds `pending`, `overrun`, the round-robin select and the FSM.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 unless stated otherwise.
1. Reset, then `btn_in=4'b0001` held → `evt_valid` rises after edge 7 with `evt_id=0`. `evt_ready=1` clears `pending[0]`. No second event while held without the macro.
2. A bounce of `btn_in[2]` high for 3 cycles, then low → no `pending` and no `evt_valid`.
3. Buttons 0, 1 and 3 pressed in the same cycle with `evt_ready=1` → events in order 0, 1, 3, each `evt_valid` separated by one idle cycle. Then press 0 again → served after 3 wraps correctly.
4. `evt_ready=0` while button 1 is pressed, released and pressed again → `evt_id` stays stable, `overrun[1]=1`. Raising `evt_ready` clears both `pending[1]` and `overrun[1]`.
5. Reset asserted during OFFER → `evt_valid`, `pending` and `overrun` are 0 immediately. A button held through reset yields one event after release of reset plus 7 cycles.
6. With `BTN_AUTO_REPEAT_EN`, REPEAT_DELAY=20, REPEAT_PERIOD=10 and `evt_ready=1`, button 0 held 45 cycles past debounce → exactly 4 events.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and constants for the button event arbiter.
package btn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    localparam int DEF_N_BTN         = 4;
    localparam int DEF_DEBOUNCE      = 16;
    localparam int DEF_REPEAT_DELAY  = 1000;
    localparam int DEF_REPEAT_PERIOD = 250;

    // Width of a counter that runs 0..v-1.
    function automatic int cnt_w(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, debounce filter and press pulse.
// BTN_AUTO_REPEAT_EN adds a held-button repeat generator that pulses like a press.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
`ifdef BTN_AUTO_REPEAT_EN
   ,parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int DBW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic           r_meta, r_sync, r_stable, r_rise;
    logic [DBW-1:0] r_db_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_meta <= btn_raw;
            r_sync <= r_meta;
            r_rise <= 1'b0;
            if (r_sync == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_stable <= r_sync;
                r_db_cnt <= '0;
                r_rise   <= r_sync;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RPMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPW   = cnt_w(RPMAX);
    localparam logic [RPW-1:0] RP_FIRST = RPW'(REPEAT_DELAY - 1);
    localparam logic [RPW-1:0] RP_NEXT  = RPW'(REPEAT_PERIOD - 1);

    logic [RPW-1:0] r_rpt_cnt;
    logic           r_rpt_first, r_rpt;

    // Counter is held at zero while released, so it restarts from the press edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
            r_rpt       <= 1'b0;
        end else begin
            r_rpt <= 1'b0;
            if (!r_stable) begin
                r_rpt_cnt   <= '0;
                r_rpt_first <= 1'b1;
            end else if (r_rpt_cnt == (r_rpt_first ? RP_FIRST : RP_NEXT)) begin
                r_rpt_cnt   <= '0;
                r_rpt_first <= 1'b0;
                r_rpt       <= 1'b1;
            end else begin
                r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
        end
    end

    assign press = r_rise | r_rpt;
`else
    assign press = r_rise;
`endif

endmodule

// File: rtl/btn_event_arbiter.sv
// Debounced buttons -> pending events -> round-robin valid/ready event stream.
// BTN_AUTO_REPEAT_EN enables auto-repeat of held buttons.
module btn_event_arbiter
    import btn_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_BTN-1:0]         btn_in,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic [N_BTN-1:0]         pending,
    output logic [N_BTN-1:0]         overrun
);

    localparam int IDW = $clog2(N_BTN);

    logic [N_BTN-1:0] w_press, w_acc_vec;
    logic [N_BTN-1:0] r_pending, r_overrun;
    logic [IDW-1:0]   r_evt_id, r_last, w_sel;
    logic             w_found, w_latch, w_accept;
    arb_state_t       r_state, w_state_nxt;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTO_REPEAT_EN
           ,.REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(btn_in[i]),
            .press  (w_press[i])
        );
    end

    // Round-robin search starting just after the last granted index.
    always_comb begin
        int idx;
        idx     = 0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int off = 1; off <= N_BTN; off++) begin
            idx = int'(r_last) + off;
            if (idx >= N_BTN) idx = idx - N_BTN;
            if (!w_found && r_pending[idx]) begin
                w_found = 1'b1;
                w_sel   = IDW'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        evt_valid   = 1'b0;
        w_latch     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_latch     = 1'b1;
                    w_state_nxt = OFFER;
                end
            end
            OFFER: begin
                evt_valid = 1'b1;
                if (evt_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_evt_id <= '0;
            r_last   <= IDW'(N_BTN - 1);
        end else begin
            r_state <= w_state_nxt;
            if (w_latch)  r_evt_id <= w_sel;
            if (w_accept) r_last   <= r_evt_id;
        end
    end

    assign w_acc_vec = w_accept ? (N_BTN'(1) << r_evt_id) : '0;

    // A press coinciding with acceptance of the same button re-arms it cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_pending <= (r_pending & ~w_acc_vec) | w_press;
            r_overrun <= (r_overrun & ~w_acc_vec) | (w_press & r_pending & ~w_acc_vec);
        end
    end

    assign evt_id  = r_evt_id;
    assign pending = r_pending;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter with DEBOUNCE_CYCLES=4.
module tb_btn_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_in;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic [3:0] pending;
    logic [3:0] overrun;

    int checks   = 0;
    int failures = 0;
    int ev_ids[$];
    int ev_cyc[$];

    always #5 clk = ~clk;

    btn_event_arbiter #(
        .N_BTN          (4),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id   (evt_id),
        .pending  (pending),
        .overrun  (overrun)
    );

    typedef struct {
        logic [3:0] btn;
        logic       rdy;
        logic       vld;
        logic [1:0] id;
        logic [3:0] pend;
        logic [3:0] ovr;
    } vec_t;

    vec_t tbl[25];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        btn_in    = '0;
        evt_ready = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Advance n cycles, logging every offered event and its cycle index.
    task automatic watch(input int n);
        for (int c = 0; c < n; c++) begin
            cyc();
            if (evt_valid) begin
                ev_ids.push_back(int'(evt_id));
                ev_cyc.push_back(c);
            end
        end
    endtask

    initial begin
        // Row k: inputs applied before edge k, outputs expected after edge k.
        for (int i = 0; i < 25; i++) begin
            tbl[i] = '{btn: 4'b0001, rdy: 1'b0, vld: 1'b0, id: 2'd0, pend: 4'b0000, ovr: 4'b0000};
            if (i >= 8)  tbl[i].rdy = 1'b1;
            if (i >= 17) tbl[i].btn = 4'b0000;
        end
        tbl[6].pend = 4'b0001;
        tbl[7].pend = 4'b0001;
        tbl[7].vld  = 1'b1;

        do_reset();
        chk("reset outputs", {evt_valid, evt_id, pending, overrun}, 32'd0);

        // 1: single press, accept, no repeat while held, release silent
        for (int i = 0; i < 25; i++) begin
            btn_in    = tbl[i].btn;
            evt_ready = tbl[i].rdy;
            cyc();
            chk($sformatf("t1 row%0d", i), {evt_valid, evt_id, pending, overrun},
                {tbl[i].vld, tbl[i].id, tbl[i].pend, tbl[i].ovr});
        end

        // 2: 3-cycle bounce rejected
        do_reset();
        evt_ready = 1'b1;
        begin
            int seen;
            seen = 0;
            btn_in = 4'b0100;
            for (int i = 0; i < 3; i++) begin
                cyc();
                if (evt_valid || pending != 0) seen++;
            end
            btn_in = 4'b0000;
            for (int i = 0; i < 15; i++) begin
                cyc();
                if (evt_valid || pending != 0) seen++;
            end
            chk("t2 bounce cycles with activity", seen, 0);
        end

        // 3: simultaneous presses served round-robin, then wrap to 0
        do_reset();
        evt_ready = 1'b1;
        ev_ids.delete(); ev_cyc.delete();
        btn_in = 4'b1011;
        watch(20);
        chk("t3 event count", ev_ids.size(), 3);
        if (ev_ids.size() == 3) begin
            chk("t3 id0", ev_ids[0], 0);
            chk("t3 id1", ev_ids[1], 1);
            chk("t3 id2", ev_ids[2], 3);
            chk("t3 first valid cycle", ev_cyc[0], 7);
            chk("t3 gap a", ev_cyc[1] - ev_cyc[0], 2);
            chk("t3 gap b", ev_cyc[2] - ev_cyc[1], 2);
        end
        btn_in = 4'b0000;
        ev_ids.delete(); ev_cyc.delete();
        watch(12);
        chk("t3 release events", ev_ids.size(), 0);
        btn_in = 4'b0001;
        watch(12);
        chk("t3 repress count", ev_ids.size(), 1);
        if (ev_ids.size() == 1) begin
            chk("t3 repress id", ev_ids[0], 0);
            chk("t3 repress cycle", ev_cyc[0], 7);
        end

        // 4: stalled consumer, second press on same button -> overrun
        do_reset();
        btn_in = 4'b0010;
        repeat (8) cyc();
        chk("t4 offer", {evt_valid, evt_id, pending, overrun}, {1'b1, 2'd1, 4'b0010, 4'b0000});
        btn_in = 4'b0000;
        repeat (8) cyc();
        chk("t4 held offer", {evt_valid, evt_id}, {1'b1, 2'd1});
        btn_in = 4'b0010;
        repeat (8) cyc();
        chk("t4 overrun", {evt_valid, evt_id, pending, overrun}, {1'b1, 2'd1, 4'b0010, 4'b0010});
        evt_ready = 1'b1;
        cyc();
        chk("t4 accept clears", {evt_valid, pending, overrun}, {1'b0, 4'b0000, 4'b0000});
        evt_ready = 1'b0;
        repeat (4) cyc();
        chk("t4 no further event", {evt_valid, pending}, {1'b0, 4'b0000});

        // 5: reset during OFFER, button held through reset
        do_reset();
        btn_in = 4'b0001;
        repeat (8) cyc();
        chk("t5 offer before reset", {evt_valid, pending}, {1'b1, 4'b0001});
        #2 reset = 1'b1;
        #1 chk("t5 async reset", {evt_valid, pending, overrun}, 32'd0);
        @(negedge clk);
        cyc();
        reset = 1'b0;
        repeat (7) cyc();
        chk("t5 not yet valid after edge 6", evt_valid, 1'b0);
        cyc();
        chk("t5 valid after edge 7", {evt_valid, evt_id}, {1'b1, 2'd0});
        evt_ready = 1'b1;
        ev_ids.delete(); ev_cyc.delete();
        watch(15);
        chk("t5 single event", ev_ids.size(), 0);

        // 6: long hold, repeat only when the feature is built in
        do_reset();
        evt_ready = 1'b1;
        ev_ids.delete(); ev_cyc.delete();
        btn_in = 4'b0001;
        watch(48);
        btn_in = 4'b0000;
        watch(30);
`ifdef BTN_AUTO_REPEAT_EN
        chk("t6 repeat events", ev_ids.size(), 4);
`else
        chk("t6 held events", ev_ids.size(), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
